// File: rtl/cmd_printer_tracker_if.sv
// Handshake bundle between the PS/2 line assembler, the dump requester
// and the screen-character writer, as seen by cmd_printer_tracker.
interface cmd_printer_tracker_if #(
  parameter int LINE_CHARS = 32
);
  logic                    start;
  logic [8*LINE_CHARS-1:0] ps2_line_content;
  logic                    ps2_line_ready;
  logic                    finish;
  logic [7:0]              char_index;
  logic [7:0]              char_data;

  modport master (
    output start,
    output ps2_line_content,
    output ps2_line_ready,
    input  finish,
    input  char_index,
    input  char_data
  );

  modport slave (
    input  start,
    input  ps2_line_content,
    input  ps2_line_ready,
    output finish,
    output char_index,
    output char_data
  );
endinterface

// File: rtl/cmd_printer_tracker.sv
// Terminal-history tracker: keeps the last NUM_LINES command lines and
// streams them as (char_index, char_data) pairs. Option: CMD_TRACKER_PROMPT_EN.
module cmd_printer_tracker #(
  parameter int         NUM_LINES  = 4,
  parameter int         LINE_CHARS = 32,
  parameter logic [7:0] BASE_INDEX = 8'h80,
  parameter int         ROW_STRIDE = 32,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input logic                  clock,
  input logic                  reset,
  cmd_printer_tracker_if.slave bus
);

  localparam int RW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CW = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;
  localparam int LW = 8 * LINE_CHARS;

  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_LINES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_CHARS - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0] hist [NUM_LINES][LINE_CHARS];
  logic [7:0] view [NUM_LINES][LINE_CHARS];

  logic          ready_q;
  logic          rise;
  logic          pend_vld;
  logic [LW-1:0] pend_line;

  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;

  logic          do_shift;
  logic [LW-1:0] shift_line;
  logic          pend_set;
  logic          pend_clr;
  logic          load;

  logic [7:0] idx_d;
  logic [7:0] dat_d;
  logic [7:0] char_index_q;
  logic [7:0] char_data_q;

  assign rise = bus.ps2_line_ready & ~ready_q;

  assign bus.finish     = (state_q == IDLE) & ~bus.start;
  assign bus.char_index = char_index_q;
  assign bus.char_data  = char_data_q;

  // State and cell-position registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next state, cell walk and capture routing; a pending line wins over
  // a fresh edge in IDLE, and the fresh edge is parked for the next clock
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    load       = 1'b0;
    do_shift   = 1'b0;
    shift_line = pend_line;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_vld) begin
          do_shift   = 1'b1;
          shift_line = pend_line;
          pend_clr   = 1'b1;
          pend_set   = rise;
        end else if (rise) begin
          do_shift   = 1'b1;
          shift_line = bus.ps2_line_content;
        end
        if (bus.start) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          load    = 1'b1;
        end
      end
      STREAM: begin
        pend_set = rise;
        if (row_q == ROW_LAST && col_q == COL_LAST) begin
          state_d = IDLE;
        end else begin
          load = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // History as it will look after this edge, so a dump started together
  // with a capture already shows the new line
  always_comb begin
    for (int r = 0; r < NUM_LINES; r++) begin
      for (int c = 0; c < LINE_CHARS; c++) begin
        view[r][c] = hist[r][c];
      end
    end
    if (do_shift) begin
      for (int r = 0; r < NUM_LINES - 1; r++) begin
        for (int c = 0; c < LINE_CHARS; c++) begin
          view[r][c] = hist[r+1][c];
        end
      end
      for (int c = 0; c < LINE_CHARS; c++) begin
        view[NUM_LINES-1][c] = shift_line[8*c +: 8];
      end
    end
  end

  // Screen index and byte of the cell about to be presented
  always_comb begin
    idx_d = BASE_INDEX
          + 8'(ROW_STRIDE) * 8'(row_d)
          + 8'(col_d);
`ifdef CMD_TRACKER_PROMPT_EN
    if (col_d == '0 && view[row_d][0] != BLANK_CHAR) begin
      dat_d = 8'h3E;
    end else begin
      dat_d = view[row_d][col_d];
    end
`else
    dat_d = view[row_d][col_d];
`endif
  end

  // History, edge detector, pending buffer and output pair
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_LINES; r++) begin
        for (int c = 0; c < LINE_CHARS; c++) begin
          hist[r][c] <= BLANK_CHAR;
        end
      end
      ready_q      <= 1'b0;
      pend_vld     <= 1'b0;
      pend_line    <= '0;
      char_index_q <= 8'h00;
      char_data_q  <= BLANK_CHAR;
    end else begin
      ready_q <= bus.ps2_line_ready;
      if (do_shift) begin
        for (int r = 0; r < NUM_LINES; r++) begin
          for (int c = 0; c < LINE_CHARS; c++) begin
            hist[r][c] <= view[r][c];
          end
        end
      end
      if (pend_set) begin
        pend_vld  <= 1'b1;
        pend_line <= bus.ps2_line_content;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
      if (load) begin
        char_index_q <= idx_d;
        char_data_q  <= dat_d;
      end
    end
  end

endmodule

// File: tb/tb_cmd_printer_tracker.sv
// Bench for cmd_printer_tracker: queue-based history model, per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_cmd_printer_tracker;

  localparam int NL  = 4;
  localparam int LC  = 32;
  localparam int TOT = NL * LC;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  cmd_printer_tracker_if #(.LINE_CHARS(LC)) bus();

  cmd_printer_tracker #(
    .NUM_LINES (NL),
    .LINE_CHARS(LC),
    .BASE_INDEX(8'h80),
    .ROW_STRIDE(32),
    .BLANK_CHAR(8'h20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [8*LC-1:0] hq [$];
  logic [8*LC-1:0] m_pend;
  bit              m_pend_v;
  bit              m_busy;
  bit              m_prev;
  bit              m_edge;
  int              m_k;
  logic [7:0]      exp_idx;
  logic [7:0]      exp_dat;
  logic [8*LC-1:0] m_drop;

  bit         chk_en = 1'b0;
  logic [7:0] seen [256];
  int         low_cnt;

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cell_idx(int k);
    int v;
    v = 8'h80 + (k / LC) * 32 + (k % LC);
    return 8'(v);
  endfunction

  function automatic logic [7:0] cell_dat(int k);
    logic [8*LC-1:0] l;
    logic [7:0]      b;
    l = hq[k / LC];
    b = l[8*(k % LC) +: 8];
`ifdef CMD_TRACKER_PROMPT_EN
    if ((k % LC) == 0 && b != 8'h20) b = 8'h3E;
`endif
    return b;
  endfunction

  function automatic void push_line(logic [8*LC-1:0] l);
    hq.push_back(l);
    if (hq.size() > NL) m_drop = hq.pop_front();
  endfunction

  function automatic logic [8*LC-1:0] mk_line(string s);
    logic [8*LC-1:0] l;
    l = {LC{8'h20}};
    for (int i = 0; i < s.len(); i++) l[8*i +: 8] = s[i];
    return l;
  endfunction

  // Reference model: history as a queue of whole lines, dump as a cell count
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hq.delete();
      for (int i = 0; i < NL; i++) hq.push_back({LC{8'h20}});
      m_pend_v = 1'b0;
      m_busy   = 1'b0;
      m_prev   = 1'b0;
      m_k      = 0;
      exp_idx  = 8'h00;
      exp_dat  = 8'h20;
    end else begin
      m_edge = bus.ps2_line_ready && !m_prev;
      m_prev = bus.ps2_line_ready;
      if (m_busy) begin
        if (m_edge) begin
          m_pend   = bus.ps2_line_content;
          m_pend_v = 1'b1;
        end
        if (m_k == TOT - 1) begin
          m_busy = 1'b0;
        end else begin
          m_k++;
          exp_idx = cell_idx(m_k);
          exp_dat = cell_dat(m_k);
        end
      end else begin
        if (m_pend_v) begin
          push_line(m_pend);
          m_pend_v = m_edge;
          if (m_edge) m_pend = bus.ps2_line_content;
        end else if (m_edge) begin
          push_line(bus.ps2_line_content);
        end
        if (bus.start) begin
          m_busy  = 1'b1;
          m_k     = 0;
          exp_idx = cell_idx(0);
          exp_dat = cell_dat(0);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      chk("finish", {7'b0, bus.finish}, {7'b0, !m_busy && !bus.start});
      chk("char_index", bus.char_index, exp_idx);
      chk("char_data", bus.char_data, exp_dat);
      if (!bus.finish && !bus.start) begin
        seen[bus.char_index] = bus.char_data;
        low_cnt++;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic send_line(string s);
    bus.ps2_line_content = mk_line(s);
    bus.ps2_line_ready   = 1'b1;
    tick();
    bus.ps2_line_ready   = 1'b0;
    tick();
  endtask

  task automatic dump(bit inject, string s);
    int n;
    for (int i = 0; i < 256; i++) seen[i] = 8'h00;
    low_cnt   = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.finish && n < 300) begin
      if (inject && n == 10) begin
        send_line(s);
        n += 2;
      end else begin
        tick();
        n++;
      end
    end
    if (n >= 300) begin
      errors++;
      checks++;
      $display("FAIL dump_timeout: finish still %b after %0d cycles", bus.finish, n);
    end
    tick();
  endtask

  logic [7:0] p_e;

  initial begin
    bus.start            = 1'b0;
    bus.ps2_line_ready   = 1'b0;
    bus.ps2_line_content = '0;
`ifdef CMD_TRACKER_PROMPT_EN
    p_e = 8'h3E;
`else
    p_e = 8'h00;
`endif
    #1 reset = 1'b1;
    tick(2);
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("rst_finish", {7'b0, bus.finish}, 8'h01);
    chk("rst_index", bus.char_index, 8'h00);
    chk("rst_data", bus.char_data, 8'h20);

    dump(1'b0, "");
    chk("blank_low_cycles", 8'(low_cnt), 8'd128);
    chk("blank_hold_index", bus.char_index, 8'hFF);
    chk("blank_first", seen[8'h80], 8'h20);
    chk("blank_last", seen[8'hFF], 8'h20);

    send_line("LS");
    dump(1'b0, "");
    chk("ls_e0", seen[8'hE0], p_e != 0 ? p_e : 8'h4C);
    chk("ls_e1", seen[8'hE1], 8'h53);
    chk("ls_e2", seen[8'hE2], 8'h20);
    chk("ls_row0", seen[8'h80], 8'h20);
    chk("ls_row2", seen[8'hC0], 8'h20);

    send_line("A");
    send_line("B");
    send_line("C");
    send_line("D");
    send_line("E");
    dump(1'b0, "");
    chk("five_80", seen[8'h80], p_e != 0 ? p_e : 8'h42);
    chk("five_a0", seen[8'hA0], p_e != 0 ? p_e : 8'h43);
    chk("five_c0", seen[8'hC0], p_e != 0 ? p_e : 8'h44);
    chk("five_e0", seen[8'hE0], p_e != 0 ? p_e : 8'h45);

    dump(1'b1, "X");
    chk("midline_old", seen[8'hE0], p_e != 0 ? p_e : 8'h45);
    dump(1'b0, "");
    chk("midline_new", seen[8'hE0], p_e != 0 ? p_e : 8'h58);
    chk("midline_prev", seen[8'hC0], p_e != 0 ? p_e : 8'h45);

    bus.ps2_line_content = mk_line("Z");
    bus.ps2_line_ready   = 1'b1;
    dump(1'b0, "");
    bus.ps2_line_ready   = 1'b0;
    tick();
    chk("simul_e0", seen[8'hE0], p_e != 0 ? p_e : 8'h5A);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.ps2_line_content = mk_line("Q");
    bus.ps2_line_ready   = 1'b1;
    tick(10);
    bus.ps2_line_ready   = 1'b0;
    tick();
    dump(1'b0, "");
    chk("hold_e0", seen[8'hE0], p_e != 0 ? p_e : 8'h51);
    chk("hold_row2", seen[8'hC0], 8'h20);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(50);
    reset = 1'b1;
    #1;
    chk("midrst_finish", {7'b0, bus.finish}, 8'h01);
    chk("midrst_index", bus.char_index, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    dump(1'b0, "");
    chk("midrst_e0", seen[8'hE0], 8'h20);
    chk("midrst_low", 8'(low_cnt), 8'd128);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
